izh_neuron_sequencer: RTL



---
 rtl/izh_neuron_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/izh_neuron_sequencer.sv
// Time-multiplexes a single Izhikevich neuron core across N_NEURONS neurons,
// holding per-neuron v/u/i state and buffering fired neurons as spike events.
module izh_neuron_sequencer #(
  parameter int          N_NEURONS  = 16,
  parameter int          IDX_W      = 4,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [16:0] V_INIT     = 17'h14100,
  parameter logic [16:0] U_INIT     = 17'h10D00
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             st_we,
  input  logic [IDX_W-1:0] st_addr,
  input  logic [16:0]      st_v,
  input  logic [16:0]      st_u,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_addr,
  input  logic [16:0]      i_data,
  output logic [16:0]      core_v,
  output logic [16:0]      core_u,
  output logic [16:0]      core_i,
  input  logic [16:0]      core_v_prime,
  input  logic [16:0]      core_u_prime,
  input  logic             core_fired,
  output logic             spk_valid,
  input  logic             spk_ready,
  output logic [IDX_W-1:0] spk_idx,
  output logic [15:0]      spk_step,
  output logic [15:0]      step_cnt
);

  localparam int               FA_W = $clog2(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_NEURONS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, FINISH} state_t;

  state_t           state;
  logic [IDX_W-1:0] k;
  logic [IDX_W-1:0] k_next;
  logic [16:0]      v_mem [N_NEURONS];
  logic [16:0]      u_mem [N_NEURONS];
  logic [16:0]      i_mem [N_NEURONS];

  logic [IDX_W+15:0] fifo_mem [FIFO_DEPTH];
  logic [IDX_W+15:0] fifo_head;
  logic [FA_W:0]     wr_ptr;
  logic [FA_W:0]     rd_ptr;
  logic              fifo_full;
  logic              pop;
  logic              push;
  logic              capture_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_full  = (wr_ptr[FA_W-1:0] == rd_ptr[FA_W-1:0]) && (wr_ptr[FA_W] != rd_ptr[FA_W]);
  assign spk_valid  = (wr_ptr != rd_ptr);
  assign fifo_head  = fifo_mem[rd_ptr[FA_W-1:0]];
  assign spk_idx    = fifo_head[IDX_W+15:16];
  assign spk_step   = fifo_head[15:0];
  assign pop        = spk_valid && spk_ready;
  assign capture_ok = !core_fired || !fifo_full || pop;
  assign push       = (state == CAPTURE) && capture_ok && core_fired;
  assign k_next     = k + IDX_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      k        <= '0;
      step_cnt <= '0;
      core_v   <= '0;
      core_u   <= '0;
      core_i   <= '0;
      for (int n = 0; n < N_NEURONS; n++) begin
        v_mem[n] <= V_INIT;
        u_mem[n] <= U_INIT;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (st_we) begin
            v_mem[st_addr] <= st_v;
            u_mem[st_addr] <= st_u;
          end
          // A host write to neuron 0 in the start cycle must reach the core directly.
          if (start) begin
            state  <= ISSUE;
            busy   <= 1'b1;
            k      <= '0;
            core_v <= (st_we && st_addr == '0) ? st_v : v_mem[0];
            core_u <= (st_we && st_addr == '0) ? st_u : u_mem[0];
            core_i <= i_mem[0];
          end
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          if (capture_ok) begin
            v_mem[k] <= core_v_prime;
            u_mem[k] <= core_u_prime;
            if (k == LAST) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state  <= ISSUE;
              k      <= k_next;
              core_v <= v_mem[k_next];
              core_u <= u_mem[k_next];
              core_i <= i_mem[k_next];
            end
          end
        end
        FINISH: begin
          state    <= IDLE;
          busy     <= 1'b0;
          k        <= '0;
          step_cnt <= step_cnt + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Input currents are writable at any time and persist across timesteps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < N_NEURONS; n++) i_mem[n] <= '0;
    end else if (i_we) begin
      i_mem[i_addr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int n = 0; n < FIFO_DEPTH; n++) fifo_mem[n] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr[FA_W-1:0]] <= {k, step_cnt};
        wr_ptr <= wr_ptr + (FA_W+1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (FA_W+1)'(1);
    end
  end

endmodule
